one_bit_round_ctrl: RTL and testbench
=====================================

# one_bit_round_ctrl

- Round-level initiator for the bit-serial permutation core.
- Accepts a host request for 12, 8 or 6 rounds and supplies the Ascon round constant for each round.
- For each round, issues a one-cycle `start_permutation` pulse and waits for the core's `perm_done` pulse.
- Reports completion to the host, or reports a watchdog error if the core stalls. Sits between the mode/host logic and the one-bit permutation FSM.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum number of cycles in WAIT before the watchdog error fires. Must be ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: host request pulse. Sampled only in IDLE.
- `rounds_sel` in 2: round count, sampled with `start`.
  - 00 → 12 rounds
  - 01 → 8 rounds
  - 10 → 6 rounds
  - 11 → treated as 12 rounds
- `perm_done` in 1: one-cycle pulse from the permutation core when a round finishes (end of final_state).
- `start_permutation` out 1: one-cycle launch pulse to the core.
- `round_const` out 8: constant for the current round. Equals {~round_idx, round_idx}.
- `round_idx` out 4: current Ascon round index, 0..11.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last round.
- `error` out 1: one-cycle pulse on watchdog expiry.

## Operation
- States:
  - IDLE: wait for `start`.
  - LAUNCH: `start_permutation`=1 for exactly this one cycle.
  - WAIT: count cycles, wait for `perm_done`.
  - FINISH: `done`=1 for one cycle.
  - FAULT: `error`=1 for one cycle.
- Transitions:
  - IDLE & `start` → LAUNCH. `round_idx` loads the start index: 0 for 12 rounds, 4 for 8 rounds, 6 for 6 rounds.
  - LAUNCH → WAIT, unconditionally. Watchdog clears to 0.
  - WAIT & `perm_done` & `round_idx`==11 → FINISH.
  - WAIT & `perm_done` & `round_idx`<11 → LAUNCH, with `round_idx`+1.
  - WAIT & no `perm_done` & watchdog==TIMEOUT_CYCLES-1 → FAULT.
  - FINISH → IDLE. FAULT → IDLE.
- `round_idx` holds its value through FINISH and FAULT. It reloads only on the next accepted `start`.
- `round_const` is a pure function of `round_idx`. Example sequence for 12 rounds: F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B.
- `round_const` is stable from LAUNCH through the end of WAIT for each round.
- Watchdog:
  - Width is $clog2(TIMEOUT_CYCLES) bits.
  - Increments each WAIT cycle and saturates; it never wraps.
  - Cleared in LAUNCH and IDLE.
- Boundary conditions:
  - `start` outside IDLE is ignored; `rounds_sel` is not re-sampled.
  - `perm_done` in IDLE, LAUNCH, FINISH or FAULT is ignored and changes no state.
  - `perm_done` on the same cycle the watchdog reaches its limit: `perm_done` wins and the round completes normally.
  - `start` in the same cycle FINISH or FAULT returns to IDLE is ignored; it is accepted only from IDLE.
  - Reset asserted mid-operation: asynchronously return to IDLE, all outputs to reset values. No `done` or `error` is emitted.
- Reset values: `start_permutation`=0, `busy`=0, `done`=0, `error`=0, `round_idx`=0, `round_const`=8'hF0, state=IDLE, watchdog=0.

## Timing
- `start` at cycle t → `busy` and `start_permutation` high at t+1.
- `perm_done` at cycle t (non-final round) → next `start_permutation` at t+1, with the incremented `round_idx` visible at t+1.
- `perm_done` at cycle t (final round) → `done` at t+1, `busy` low at t+2.
- Per-round overhead is 2 cycles (LAUNCH plus the cycle `perm_done` is sampled), in addition to the core latency.
- Watchdog: with no `perm_done`, `error` pulses exactly TIMEOUT_CYCLES+1 cycles after the `start_permutation` cycle.
- `start_permutation`, `done` and `error` are decoded from the state register only, and are glitch-free relative to the clock.
- `done` and `error` are never high simultaneously.

## Structure
- Shared package `one_bit_pkg` holds:
  - the state enum: IDLE, LAUNCH, WAIT, FINISH, FAULT in 3 bits;
  - rounds_sel encodings;
  - start-index constants: 0, 4, 6;
  - FINAL_ROUND = 11.
- Sub-module `one_bit_wdog`: saturating counter with clear, enable and expiry flag, parameterised by TIMEOUT_CYCLES.
- Next-state logic and output decode live in one always_comb with defaults; the state register lives in a separate always_ff.

## Test plan
- Reset then `start` with `rounds_sel`=00, core model returning `perm_done` 450 cycles after each launch → 12 `start_permutation` pulses, constants F0…4B in order, single `done`, `busy` low 1 cycle later.
- `rounds_sel`=10 → 6 launches with constants 96, 87, 78, 69, 5A, 4B, then `done`.
- `rounds_sel`=01, with `perm_done` returned the cycle after each launch (minimum latency) → 8 rounds, launches spaced exactly 2 cycles apart, constants B4…4B.
- TIMEOUT_CYCLES=16, core never responds → `error` pulse 17 cycles after the launch, `done` never asserted, back in IDLE. A subsequent `start` runs normally.
- During round 3 of a 12-round run: inject a stray `start` and a `perm_done` while in LAUNCH → both ignored and the sequence is unaffected. Then assert `rst` mid-WAIT → all outputs drop to reset values immediately, `round_const`=F0, no `done`.

Source files
------------

// File: rtl/one_bit_pkg.sv
// Shared definitions for the one-bit permutation round controller:
// FSM state encoding, rounds_sel encodings, start indices and helpers.
package one_bit_pkg;

   // Controller FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_FINISH = 3'd3,
      ST_FAULT  = 3'd4
   } state_t;

   // rounds_sel encodings; the spare code behaves as a full 12-round run
   localparam logic [1:0] SEL_12     = 2'b00;
   localparam logic [1:0] SEL_8      = 2'b01;
   localparam logic [1:0] SEL_6      = 2'b10;
   localparam logic [1:0] SEL_12_ALT = 2'b11;

   // First Ascon round index for each round count (runs always end at 11)
   localparam logic [3:0] START_IDX_12 = 4'd0;
   localparam logic [3:0] START_IDX_8  = 4'd4;
   localparam logic [3:0] START_IDX_6  = 4'd6;
   localparam logic [3:0] FINAL_ROUND  = 4'd11;

   // Map a rounds_sel code to its starting round index
   function automatic logic [3:0] start_idx(input logic [1:0] sel);
      logic [3:0] idx;
      case (sel)
         SEL_8:              idx = START_IDX_8;
         SEL_6:              idx = START_IDX_6;
         SEL_12, SEL_12_ALT: idx = START_IDX_12;
         default:            idx = START_IDX_12;
      endcase
      return idx;
   endfunction

   // Ascon round constant: upper nibble is the complement of the index
   function automatic logic [7:0] round_const_of(input logic [3:0] idx);
      return {~idx, idx};
   endfunction

endpackage

// File: rtl/one_bit_wdog.sv
// Saturating watchdog counter for the round controller. Counts enabled
// cycles, clears synchronously, and flags when it sits at TIMEOUT_CYCLES-1.
module one_bit_wdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] r_cnt;
   logic         w_at_limit;

   assign w_at_limit = (r_cnt == LIMIT);
   assign o_expired  = w_at_limit;

   // Count enabled cycles; stop at the limit so the value never wraps
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_en && !w_at_limit)
         r_cnt <= r_cnt + W'(1);
   end

endmodule

// File: rtl/one_bit_round_ctrl.sv
// Round-level initiator for the bit-serial permutation core. Launches one
// permutation per Ascon round, tracks the round index/constant, and reports
// completion or a watchdog stall to the host.
module one_bit_round_ctrl
   import one_bit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024   // must be >= 2
) (
   input  logic       clk,
   input  logic       rst,               // asynchronous, active low
   input  logic       start,
   input  logic [1:0] rounds_sel,
   input  logic       perm_done,
   output logic       start_permutation,
   output logic [7:0] round_const,
   output logic [3:0] round_idx,
   output logic       busy,
   output logic       done,
   output logic       error
);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_round_idx;
   logic [3:0] w_round_idx_nxt;

   // Pulse/level outputs are registered from the next-state decode so they
   // always equal a decode of the current state with no combinational glitch.
   logic       r_start_perm, w_start_perm_nxt;
   logic       r_busy,       w_busy_nxt;
   logic       r_done,       w_done_nxt;
   logic       r_error,      w_error_nxt;

   logic       w_wd_clr;
   logic       w_wd_en;
   logic       w_wd_expired;

   // Watchdog only runs while waiting on the core; it restarts every launch
   assign w_wd_clr = (r_state == ST_IDLE) || (r_state == ST_LAUNCH);
   assign w_wd_en  = (r_state == ST_WAIT);

   one_bit_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_clr     (w_wd_clr),
      .i_en      (w_wd_en),
      .o_expired (w_wd_expired)
   );

   // Next-state, round index update and output decode of the next state
   always_comb begin
      w_state_nxt     = r_state;
      w_round_idx_nxt = r_round_idx;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt     = ST_LAUNCH;
               w_round_idx_nxt = start_idx(rounds_sel);
            end
         end
         ST_LAUNCH: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // perm_done has priority over a watchdog expiry in the same cycle
            if (perm_done) begin
               if (r_round_idx == FINAL_ROUND) begin
                  w_state_nxt = ST_FINISH;
               end else begin
                  w_state_nxt     = ST_LAUNCH;
                  w_round_idx_nxt = r_round_idx + 4'd1;
               end
            end else if (w_wd_expired) begin
               w_state_nxt = ST_FAULT;
            end
         end
         ST_FINISH: w_state_nxt = ST_IDLE;
         ST_FAULT:  w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase

      w_start_perm_nxt = (w_state_nxt == ST_LAUNCH);
      w_busy_nxt       = (w_state_nxt != ST_IDLE);
      w_done_nxt       = (w_state_nxt == ST_FINISH);
      w_error_nxt      = (w_state_nxt == ST_FAULT);
   end

   // State, round index and registered output flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_round_idx  <= START_IDX_12;
         r_start_perm <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_round_idx  <= w_round_idx_nxt;
         r_start_perm <= w_start_perm_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_error      <= w_error_nxt;
      end
   end

   assign start_permutation = r_start_perm;
   assign busy              = r_busy;
   assign done              = r_done;
   assign error             = r_error;
   assign round_idx         = r_round_idx;
   assign round_const       = round_const_of(r_round_idx);

endmodule

// File: tb/tb_one_bit_round_ctrl.sv
// Directed bench for one_bit_round_ctrl: a default-timeout instance for the
// normal/long-latency runs and a TIMEOUT_CYCLES=16 instance for watchdog cases.
module tb_one_bit_round_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       use16;
   logic       start_in, pd_in;
   logic [1:0] sel_in;

   logic       a_start, a_pd, b_start, b_pd;
   logic       a_sp, a_busy, a_done, a_err;
   logic       b_sp, b_busy, b_done, b_err;
   logic [7:0] a_rc, b_rc;
   logic [3:0] a_ri, b_ri;

   logic       o_sp, o_busy, o_done, o_err;
   logic [7:0] o_rc;
   logic [3:0] o_ri;

   assign a_start = use16 ? 1'b0 : start_in;
   assign a_pd    = use16 ? 1'b0 : pd_in;
   assign b_start = use16 ? start_in : 1'b0;
   assign b_pd    = use16 ? pd_in : 1'b0;

   assign o_sp   = use16 ? b_sp   : a_sp;
   assign o_busy = use16 ? b_busy : a_busy;
   assign o_done = use16 ? b_done : a_done;
   assign o_err  = use16 ? b_err  : a_err;
   assign o_rc   = use16 ? b_rc   : a_rc;
   assign o_ri   = use16 ? b_ri   : a_ri;

   one_bit_round_ctrl u_dut (
      .clk (clk), .rst (rst), .start (a_start), .rounds_sel (sel_in),
      .perm_done (a_pd), .start_permutation (a_sp), .round_const (a_rc),
      .round_idx (a_ri), .busy (a_busy), .done (a_done), .error (a_err)
   );

   one_bit_round_ctrl #(.TIMEOUT_CYCLES (16)) u_dut16 (
      .clk (clk), .rst (rst), .start (b_start), .rounds_sel (sel_in),
      .perm_done (b_pd), .start_permutation (b_sp), .round_const (b_rc),
      .round_idx (b_ri), .busy (b_busy), .done (b_done), .error (b_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rc_tab [0:11];

   typedef struct {
      bit         dut16;
      logic [1:0] sel;
      int         lat;
      int         n_rounds;
      int         first_idx;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wait(input int idx);
      chk("wait_no_launch", {31'd0, o_sp}, 0);
      chk("wait_busy", {31'd0, o_busy}, 1);
      chk("wait_const_stable", {24'd0, o_rc}, {24'd0, rc_tab[idx]});
      chk("wait_no_done_err", {30'd0, o_done, o_err}, 0);
   endtask

   // Entered with LAUNCH visible; leaves with the perm_done cycle consumed
   task automatic do_round(input int idx, input int lat, input bit stray);
      chk("launch_pulse", {31'd0, o_sp}, 1);
      chk("launch_busy", {31'd0, o_busy}, 1);
      chk("launch_idx", {28'd0, o_ri}, idx);
      chk("launch_const", {24'd0, o_rc}, {24'd0, rc_tab[idx]});
      if (stray) begin
         start_in = 1'b1;
         pd_in    = 1'b1;
         sel_in   = 2'b10;
      end
      tick();
      start_in = 1'b0;
      pd_in    = 1'b0;
      if (stray) chk("stray_idx", {28'd0, o_ri}, idx);
      for (int k = 1; k < lat; k++) begin
         chk_wait(idx);
         tick();
      end
      chk_wait(idx);
      pd_in = 1'b1;
      tick();
      pd_in = 1'b0;
   endtask

   task automatic run(input bit d16, input logic [1:0] sel, input int lat,
                      input int n, input int first);
      use16    = d16;
      sel_in   = sel;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      sel_in   = ~sel;
      for (int r = 0; r < n; r++) do_round(first + r, lat, 1'b0);
      chk("finish_done", {31'd0, o_done}, 1);
      chk("finish_busy", {31'd0, o_busy}, 1);
      chk("finish_no_err_launch", {30'd0, o_err, o_sp}, 0);
      chk("finish_idx", {28'd0, o_ri}, 11);
      start_in = 1'b1;          // arrives while FINISH returns to IDLE
      tick();
      start_in = 1'b0;
      chk("idle_busy", {31'd0, o_busy}, 0);
      chk("idle_done_drop", {31'd0, o_done}, 0);
      chk("idle_idx_held", {28'd0, o_ri}, 11);
      tick();
      chk("finish_start_ignored", {30'd0, o_sp, o_busy}, 0);
   endtask

   initial begin
      int cnt;
      rc_tab = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
      vecs[0] = '{1'b0, 2'b00, 450, 12, 0};
      vecs[1] = '{1'b0, 2'b10, 450,  6, 6};
      vecs[2] = '{1'b0, 2'b01,   1,  8, 4};
      vecs[3] = '{1'b0, 2'b11,   2, 12, 0};
      vecs[4] = '{1'b1, 2'b10,  16,  6, 6};   // perm_done on the watchdog limit
      vecs[5] = '{1'b1, 2'b00,   1, 12, 0};

      rst = 1'b0; use16 = 1'b0; start_in = 1'b0; pd_in = 1'b0; sel_in = 2'b00;
      tick(); tick();
      chk("rst_outs_a", {28'd0, a_sp, a_busy, a_done, a_err}, 0);
      chk("rst_idx_a", {28'd0, a_ri}, 0);
      chk("rst_const_a", {24'd0, a_rc}, 32'hF0);
      chk("rst_outs_b", {28'd0, b_sp, b_busy, b_done, b_err}, 0);
      chk("rst_const_b", {24'd0, b_rc}, 32'hF0);
      rst = 1'b1;
      tick();
      chk("idle_after_rst", {30'd0, a_busy, a_sp}, 0);

      foreach (vecs[i])
         run(vecs[i].dut16, vecs[i].sel, vecs[i].lat, vecs[i].n_rounds, vecs[i].first_idx);

      // Watchdog: core never answers on the 16-cycle instance
      use16 = 1'b1; sel_in = 2'b00; start_in = 1'b1;
      tick();
      start_in = 1'b0;
      chk("stall_launch", {31'd0, o_sp}, 1);
      cnt = 0;
      while (cnt < 40) begin
         tick();
         cnt++;
         chk("stall_no_done", {31'd0, o_done}, 0);
         if (o_err) break;
      end
      chk("stall_err_latency", cnt, 17);
      chk("fault_busy_idx", {27'd0, o_busy, o_ri}, {27'd0, 1'b1, 4'd0});
      start_in = 1'b1;          // arrives while FAULT returns to IDLE
      tick();
      start_in = 1'b0;
      chk("fault_to_idle", {29'd0, o_busy, o_err, o_done}, 0);
      tick();
      chk("fault_start_ignored", {30'd0, o_sp, o_busy}, 0);
      run(1'b1, 2'b10, 3, 6, 6);

      // Stray start/perm_done in LAUNCH of round 3, then reset mid-WAIT
      use16 = 1'b0; sel_in = 2'b00; start_in = 1'b1;
      tick();
      start_in = 1'b0;
      for (int r = 0; r < 3; r++) do_round(r, 5, 1'b0);
      do_round(3, 4, 1'b1);
      chk("after_stray_launch", {31'd0, o_sp}, 1);
      chk("after_stray_const", {24'd0, o_rc}, 32'hB4);
      tick(); tick(); tick();
      chk("pre_rst_wait", {30'd0, o_busy, o_sp}, 2);
      rst = 1'b0;
      #1;
      chk("midrst_outs", {28'd0, o_sp, o_busy, o_done, o_err}, 0);
      chk("midrst_idx", {28'd0, o_ri}, 0);
      chk("midrst_const", {24'd0, o_rc}, 32'hF0);
      tick(); tick();
      chk("midrst_no_done_err", {30'd0, o_done, o_err}, 0);
      rst = 1'b1;
      tick();
      chk("post_rst_idle", {30'd0, o_busy, o_sp}, 0);
      run(1'b0, 2'b01, 1, 8, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
